// File: rtl/sop_cube_engine.sv
// sop_cube_engine: run-time-loadable PLA evaluator, one cube tested per cycle behind valid/ready.
module sop_cube_engine #(
  parameter int N_IN   = 6,
  parameter int N_OUT  = 3,
  parameter int N_CUBE = 16,
  parameter int AW     = (N_CUBE > 1) ? $clog2(N_CUBE) : 1,
  parameter int CW     = $clog2(N_CUBE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [2*N_IN-1:0] cfg_cube,
  input  logic [N_OUT-1:0]  cfg_plane,
  input  logic              ctl_we,
  input  logic [CW-1:0]     ctl_ncube,
  input  logic [N_OUT-1:0]  ctl_pol,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_vec
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t r_state, w_next;
  logic [2*N_IN-1:0] r_cube [N_CUBE];
  logic [N_OUT-1:0]  r_plane [N_CUBE];
  logic [CW-1:0]     r_ncube, w_ncube;
  logic [N_OUT-1:0]  r_pol, w_pol, r_acc, w_acc, r_out;
  logic [N_IN-1:0]   r_vec;
  logic [AW-1:0]     r_idx;
  logic r_err, w_idle, w_accept, w_match, w_last, w_addr_ok, w_cfg_ok, w_ctl_ok, w_err;
  assign w_idle    = r_state == IDLE;
  assign in_ready  = w_idle & ~rst;
  assign w_accept  = in_valid & in_ready;
  assign w_addr_ok = 32'(cfg_addr) < N_CUBE;
  assign w_cfg_ok  = cfg_we & w_idle & w_addr_ok;
  assign w_ctl_ok  = ctl_we & w_idle;
  assign w_err     = ((cfg_we | ctl_we) & ~w_idle) | (cfg_we & ~w_addr_ok);
  // a control write in the accept cycle already governs the scan about to start
  assign w_ncube   = w_ctl_ok ? ((32'(ctl_ncube) > N_CUBE) ? CW'(N_CUBE) : ctl_ncube) : r_ncube;
  assign w_pol     = w_ctl_ok ? ctl_pol : r_pol;
  assign w_last    = CW'(r_idx) == r_ncube - CW'(1);
  assign w_acc     = r_acc | (w_match ? r_plane[r_idx] : '0);
  assign out_valid = r_state == DONE;
  assign out_vec   = r_out;
  assign cfg_err   = r_err;
  always_comb begin
    w_match = 1'b1;
    for (int i = 0; i < N_IN; i++)
      w_match = w_match & ((r_cube[r_idx][2*i +: 2] == 2'b00) ||
                           (r_cube[r_idx][2*i +: 2] == (r_vec[i] ? 2'b01 : 2'b10)));
  end
  always_comb begin
    w_next = r_state == IDLE ? (w_accept ? (w_ncube == '0 ? DONE : SCAN) : IDLE) :
             r_state == SCAN ? (w_last ? DONE : SCAN) :
             (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CUBE; i++) begin
        r_cube[i]  <= '1;
        r_plane[i] <= '0;
      end
      r_ncube <= '0;
      r_pol   <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_idx   <= '0;
      r_vec   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err   <= w_err;
      r_ncube <= w_ncube;
      r_pol   <= w_pol;
      if (w_cfg_ok) begin
        r_cube[cfg_addr]  <= cfg_cube;
        r_plane[cfg_addr] <= cfg_plane;
      end
      if (w_accept) begin
        r_vec <= in_vec;
        r_acc <= '0;
        r_idx <= '0;
        if (w_ncube == '0) r_out <= w_pol;
      end
      if (r_state == SCAN) begin
        r_acc <= w_acc;
        r_idx <= r_idx + 1'b1;
        if (w_last) r_out <= w_acc ^ r_pol;
      end
    end
  end
endmodule

// File: tb/tb_sop_cube_engine.sv
// tb_sop_cube_engine: directed vectors with hand-computed results for sop_cube_engine.
module tb_sop_cube_engine;
  logic clk = 0, rst = 1;
  logic cfg_we = 0, ctl_we = 0, in_valid = 0, out_ready = 0;
  logic [3:0] cfg_addr = 0;
  logic [11:0] cfg_cube = 0;
  logic [2:0] cfg_plane = 0, ctl_pol = 0;
  logic [4:0] ctl_ncube = 0;
  logic [5:0] in_vec = 0;
  logic cfg_err, in_ready, out_valid;
  logic [2:0] out_vec;
  int n_chk = 0, n_fail = 0, lat = 0, seen = 0;

  sop_cube_engine dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_cube(cfg_cube),
    .cfg_plane(cfg_plane), .ctl_we(ctl_we), .ctl_ncube(ctl_ncube), .ctl_pol(ctl_pol),
    .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cube(input logic [3:0] a, input logic [11:0] c, input logic [2:0] p);
    cfg_we = 1; cfg_addr = a; cfg_cube = c; cfg_plane = p;
    tick;
    cfg_we = 0;
  endtask

  task automatic wr_ctl(input logic [4:0] n, input logic [2:0] p);
    ctl_we = 1; ctl_ncube = n; ctl_pol = p;
    tick;
    ctl_we = 0;
    chk("idle_write_no_err", cfg_err, 0);
  endtask

  task automatic start(input logic [5:0] v);
    int w = 0;
    while (!in_ready && w < 64) begin tick; w++; end
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1; in_vec = v;
    tick;
    in_valid = 0;
    lat = 1;
  endtask

  task automatic finish(input logic [2:0] e, input int el, input int hold);
    while (!out_valid && lat < 64) begin tick; lat++; end
    chk("out_valid", out_valid, 1);
    if (el >= 0) chk("latency", lat, el);
    chk("out_vec", out_vec, e);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_valid", out_valid, 1);
      chk("hold_vec", out_vec, e);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("in_ready_after_handshake", in_ready, 1);
    chk("out_vec_held", out_vec, e);
  endtask

  initial begin
    tick; tick;
    chk("rst_in_ready", in_ready, 0);
    rst = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_out_vec", out_vec, 0);
    chk("post_rst_cfg_err", cfg_err, 0);
    tick;
    // basic two-cube cover: input0 or input3 drives output 0
    wr_cube(0, 12'h001, 3'b001);
    wr_cube(1, 12'h040, 3'b001);
    wr_ctl(2, 3'b000);
    start(6'b001000); finish(3'b001, 3, 0);
    start(6'b000000); finish(3'b000, 3, 0);
    // polarity on output 1
    wr_cube(0, 12'h011, 3'b010);
    wr_ctl(1, 3'b010);
    start(6'b000101); finish(3'b000, 2, 0);
    start(6'b000001); finish(3'b010, 2, 5);
    // write rejected while busy
    wr_ctl(2, 3'b000);
    start(6'b000101);
    cfg_we = 1; cfg_addr = 0; cfg_cube = 12'h000; cfg_plane = 3'b111;
    tick; lat++;
    cfg_we = 0;
    chk("busy_err_pulse", cfg_err, 1);
    tick; lat++;
    chk("busy_err_clear", cfg_err, 0);
    finish(3'b010, 3, 0);
    start(6'b000101); finish(3'b010, 3, 0);
    // empty table: result is polarity only
    wr_ctl(0, 3'b101);
    start(6'b110011); finish(3'b101, 1, 0);
    // oversized count clamps to 16
    wr_ctl(5'd31, 3'b000);
    start(6'b000101); finish(3'b010, 17, 0);
    // reset two cycles into a full scan
    wr_ctl(16, 3'b000);
    start(6'b000101);
    tick;
    rst = 1;
    tick;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    rst = 0;
    #1;
    chk("abort_rdy_after", in_ready, 1);
    for (int i = 0; i < 20; i++) begin tick; if (out_valid) seen++; end
    chk("abort_no_valid", seen, 0);
    start(6'b000101); finish(3'b000, 1, 0);
    wr_ctl(2, 3'b000);
    start(6'b111111); finish(3'b000, 3, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
